// File: rtl/rot_tile_sched.sv
// Tile scheduler for the rotate engine: walks the source image in 4x4 tiles and
// issues 4 row reads then 4 rotated (90 deg clockwise) column writes per tile.
module rot_tile_sched #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 12
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET_N,
    input  logic              I_GO,
    input  logic              I_ABORT,
    input  logic [ADDR_W-1:0] I_SRC_ADDR,
    input  logic [ADDR_W-1:0] I_DST_ADDR,
    input  logic [DIM_W-1:0]  I_WIDTH,
    input  logic [DIM_W-1:0]  I_HEIGHT,
    input  logic              I_DMA_READY,
    output logic              O_START,
    output logic [ADDR_W-1:0] O_ADDR,
    output logic              O_WRITE,
    output logic              O_SIZE,
    output logic              O_COUNT,
    output logic [1:0]        O_ROW_SEL,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic              O_ERR,
    output logic              O_ABORTED
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ADV,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [DIM_W-1:0]  w_q, h_q;
    logic [DIM_W-1:0]  tx_q, tx_d, ty_q, ty_d;
    logic [1:0]        k_q, k_d;
    logic              wr_phase_q, wr_phase_d;
    logic              wait_first_q;
    logic              abort_pend_q;
    logic [ADDR_W-1:0] addr_q, next_addr;
    logic              write_q;
    logic [1:0]        row_sel_q;

    logic geom_ok, accept, load_cmd, start, done, err, aborted;
    logic last_k, last_tx, last_ty;

    assign geom_ok = (I_WIDTH != '0) && (I_HEIGHT != '0) &&
                     (I_WIDTH[1:0] == 2'b00) && (I_HEIGHT[1:0] == 2'b00);
    assign last_k  = (k_q == 2'd3);
    assign last_tx = (tx_q == w_q - DIM_W'(4));
    assign last_ty = (ty_q == h_q - DIM_W'(4));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        k_d        = k_q;
        wr_phase_d = wr_phase_q;
        accept     = 1'b0;
        load_cmd   = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        aborted    = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_GO) begin
                    if (geom_ok) begin
                        accept     = 1'b1;
                        load_cmd   = 1'b1;
                        tx_d       = '0;
                        ty_d       = '0;
                        k_d        = '0;
                        wr_phase_d = 1'b0;
                        state_d    = ISSUE;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Abort wins over ready so no command leaves once abort is seen.
                if (I_ABORT) begin
                    aborted = 1'b1;
                    state_d = IDLE;
                end else if (I_DMA_READY) begin
                    start   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Ready is still stale in the first WAIT cycle.
                if (!wait_first_q && I_DMA_READY) begin
                    if (abort_pend_q || I_ABORT) begin
                        aborted = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ADV;
                    end
                end
            end
            ADV: begin
                k_d = k_q + 2'd1;
                if (last_k) begin
                    wr_phase_d = ~wr_phase_q;
                    if (wr_phase_q) begin
                        if (last_tx) begin
                            tx_d = '0;
                            ty_d = ty_q + DIM_W'(4);
                        end else begin
                            tx_d = tx_q + DIM_W'(4);
                        end
                    end
                end
                if (wr_phase_q && last_k && last_tx && last_ty) begin
                    state_d = FIN;
                end else begin
                    load_cmd = 1'b1;
                    state_d  = ISSUE;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address of the command about to enter ISSUE, from the next tile indices.
    always_comb begin
        logic [ADDR_W-1:0] line;
        line      = '0;
        next_addr = '0;
        if (accept) begin
            next_addr = I_SRC_ADDR;
        end else if (!wr_phase_d) begin
            line      = ADDR_W'(ty_d) + ADDR_W'(k_d);
            next_addr = src_q + line * ADDR_W'(w_q) + ADDR_W'(tx_d);
        end else begin
            line      = ADDR_W'(tx_d) + ADDR_W'(k_d);
            next_addr = dst_q + line * ADDR_W'(h_q) + ADDR_W'(h_q)
                        - ADDR_W'(4) - ADDR_W'(ty_d);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            w_q          <= '0;
            h_q          <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            k_q          <= '0;
            wr_phase_q   <= 1'b0;
            wait_first_q <= 1'b0;
            abort_pend_q <= 1'b0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            row_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            k_q          <= k_d;
            wr_phase_q   <= wr_phase_d;
            wait_first_q <= start;
            abort_pend_q <= (state_q == WAIT) ? (abort_pend_q | I_ABORT) : 1'b0;
            if (accept) begin
                src_q <= I_SRC_ADDR;
                dst_q <= I_DST_ADDR;
                w_q   <= I_WIDTH;
                h_q   <= I_HEIGHT;
            end
            if (state_d == IDLE) begin
                addr_q    <= '0;
                write_q   <= 1'b0;
                row_sel_q <= '0;
            end else if (load_cmd) begin
                addr_q    <= next_addr;
                write_q   <= wr_phase_d;
                row_sel_q <= k_d;
            end
        end
    end

    assign O_START   = start;
    assign O_ADDR    = addr_q;
    assign O_WRITE   = write_q;
    assign O_SIZE    = 1'b1;
    assign O_COUNT   = 1'b0;
    assign O_ROW_SEL = row_sel_q;
    assign O_BUSY    = (state_q != IDLE);
    assign O_DONE    = done;
    assign O_ERR     = err;
    assign O_ABORTED = aborted;

endmodule

// File: tb/tb_rot_tile_sched.sv
// Self-checking bench for rot_tile_sched: a command-list model built from the
// tile-walk rules, a 3-cycle DMA responder, and directed job scenarios.
module tb_rot_tile_sched;

    localparam int ADDR_W = 32;
    localparam int DIM_W  = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              go = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] src = '0;
    logic [ADDR_W-1:0] dst = '0;
    logic [DIM_W-1:0]  width = '0;
    logic [DIM_W-1:0]  height = '0;
    logic              ready = 1'b1;
    logic              o_start, o_write, o_size, o_count, o_busy, o_done, o_err, o_aborted;
    logic [ADDR_W-1:0] o_addr;
    logic [1:0]        o_row_sel;

    always #5 clk = ~clk;

    rot_tile_sched #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .I_HCLK     (clk),
        .I_HRESET_N (rst_n),
        .I_GO       (go),
        .I_ABORT    (abort),
        .I_SRC_ADDR (src),
        .I_DST_ADDR (dst),
        .I_WIDTH    (width),
        .I_HEIGHT   (height),
        .I_DMA_READY(ready),
        .O_START    (o_start),
        .O_ADDR     (o_addr),
        .O_WRITE    (o_write),
        .O_SIZE     (o_size),
        .O_COUNT    (o_count),
        .O_ROW_SEL  (o_row_sel),
        .O_BUSY     (o_busy),
        .O_DONE     (o_done),
        .O_ERR      (o_err),
        .O_ABORTED  (o_aborted)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  sel;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [31:0] log_q[$];
    int tests = 0;
    int fails = 0;
    int start_cnt = 0, done_cnt = 0, err_cnt = 0, abort_cnt = 0;
    bit hold = 1'b0;

    localparam logic [31:0] T1_ADDR[8] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                           32'h2000, 32'h2004, 32'h2008, 32'h200C};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected command list straight from the tile-walk rules.
    task automatic build_job(input logic [31:0] s, input logic [31:0] d, input int w, input int h);
        cmd_t c;
        for (int ty = 0; ty < h; ty += 4) begin
            for (int tx = 0; tx < w; tx += 4) begin
                for (int r = 0; r < 4; r++) begin
                    c.addr = s + 32'((ty + r) * w + tx);
                    c.wr   = 1'b0;
                    c.sel  = 2'(r);
                    exp_q.push_back(c);
                end
                for (int cc = 0; cc < 4; cc++) begin
                    c.addr = d + 32'((tx + cc) * h + (h - 4 - ty));
                    c.wr   = 1'b1;
                    c.sel  = 2'(cc);
                    exp_q.push_back(c);
                end
            end
        end
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return start_cnt;
            1:       return done_cnt;
            2:       return abort_cnt;
            default: return err_cnt;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (cnt_of(which) >= target) break;
        end
        check(name, 64'(cnt_of(which) >= target), 64'd1);
    endtask

    // Drives GO in cycle n, then scrambles the geometry to prove it was latched.
    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input int w, input int h);
        exp_q.delete();
        build_job(s, d, w, h);
        log_q.delete();
        @(posedge clk);
        #1;
        src    = s;
        dst    = d;
        width  = DIM_W'(w);
        height = DIM_W'(h);
        go     = 1'b1;
        @(posedge clk);
        #1;
        go     = 1'b0;
        src    = 32'hDEAD_0000;
        dst    = 32'hBEEF_0000;
        width  = 12'd0;
        height = 12'd6;
    endtask

    // DMA responder: ready drops after a strobe and returns 3 cycles after it.
    initial begin
        int cnt;
        logic s;
        cnt = 0;
        forever begin
            @(negedge clk);
            s = o_start;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt   = 0;
                ready = !hold;
            end else if (s) begin
                cnt   = 2;
                ready = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                ready = (cnt == 0) && !hold;
            end else begin
                ready = !hold;
            end
        end
    end

    // Compare process: every strobe is matched against the model's next command.
    always @(negedge clk) begin
        if (rst_n) begin
            check("pulse_exclusive", 64'($countones({o_done, o_err, o_aborted}) <= 1), 64'd1);
            check("size_count_const", {62'd0, o_size, o_count}, 64'b10);
            if (!o_busy)
                check("idle_cmd_zero", {29'd0, o_addr, o_write, o_row_sel}, 64'd0);
            if (o_start) begin
                start_cnt++;
                log_q.push_back(o_addr);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: got addr 0x%0h, expected no command", o_addr);
                end else begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    check("cmd_addr", 64'(o_addr), 64'(e.addr));
                    check("cmd_write", 64'(o_write), 64'(e.wr));
                    check("cmd_row_sel", 64'(o_row_sel), 64'(e.sel));
                end
            end
            if (o_done) begin
                done_cnt++;
                check("done_queue_drained", 64'(exp_q.size()), 64'd0);
            end
            if (o_err) err_cnt++;
            if (o_aborted) abort_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, a0, e0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_start, o_addr, o_write, o_row_sel, o_busy, o_done, o_err, o_aborted, o_count},
              64'd0);
        check("reset_size", 64'(o_size), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 64'(o_busy), 64'd0);

        // 4x4 minimum job
        s0 = start_cnt; d0 = done_cnt; a0 = abort_cnt; e0 = err_cnt;
        start_job(32'h1000, 32'h2000, 4, 4);
        @(negedge clk);
        check("go_to_start_latency", 64'(o_start), 64'd1);
        check("busy_after_go", 64'(o_busy), 64'd1);
        wait_for(1, d0 + 1, 200, "t1_done_seen");
        check("t1_strobes", 64'(start_cnt - s0), 64'd8);
        for (int i = 0; i < 8; i++) check("t1_literal_addr", 64'(log_q[i]), 64'(T1_ADDR[i]));
        @(negedge clk);
        check("t1_busy_cleared", 64'(o_busy), 64'd0);
        check("t1_single_done", 64'(done_cnt - d0), 64'd1);
        check("t1_no_err_abort", 64'((abort_cnt - a0) + (err_cnt - e0)), 64'd0);

        // 8x4: two tiles along x
        s0 = start_cnt; d0 = done_cnt;
        start_job(32'h1000, 32'h2000, 8, 4);
        wait_for(1, d0 + 1, 400, "t2_done_seen");
        check("t2_strobes", 64'(start_cnt - s0), 64'd16);
        check("t2_rd1", 64'(log_q[1]), 64'h1008);
        check("t2_rd3", 64'(log_q[3]), 64'h1018);
        check("t2_wr3", 64'(log_q[7]), 64'h200C);
        check("t2_tile1_rd0", 64'(log_q[8]), 64'h1004);
        check("t2_tile1_rd3", 64'(log_q[11]), 64'h101C);
        check("t2_tile1_wr0", 64'(log_q[12]), 64'h2010);
        check("t2_tile1_wr3", 64'(log_q[15]), 64'h201C);

        // 4x8: two tiles along y
        s0 = start_cnt; d0 = done_cnt;
        start_job(32'h1000, 32'h2000, 4, 8);
        wait_for(1, d0 + 1, 400, "t3_done_seen");
        check("t3_strobes", 64'(start_cnt - s0), 64'd16);
        check("t3_ty0_wr0", 64'(log_q[4]), 64'h2004);
        check("t3_ty0_wr3", 64'(log_q[7]), 64'h201C);
        check("t3_ty4_rd0", 64'(log_q[8]), 64'h1010);
        check("t3_ty4_rd3", 64'(log_q[11]), 64'h101C);
        check("t3_ty4_wr0", 64'(log_q[12]), 64'h2000);
        check("t3_ty4_wr2", 64'(log_q[14]), 64'h2010);
        check("t3_ty4_wr3", 64'(log_q[15]), 64'h2018);

        // Invalid geometry: W=6, then H=0
        for (int t = 0; t < 2; t++) begin
            s0 = start_cnt; e0 = err_cnt;
            @(posedge clk);
            #1;
            width  = (t == 0) ? 12'd6 : 12'd4;
            height = (t == 0) ? 12'd4 : 12'd0;
            go     = 1'b1;
            @(negedge clk);
            check("bad_geom_err_pulse", 64'(o_err), 64'd1);
            check("bad_geom_not_busy", 64'(o_busy), 64'd0);
            @(posedge clk);
            #1;
            go = 1'b0;
            repeat (5) begin
                @(negedge clk);
                check("bad_geom_stays_idle", 64'({o_busy, o_start}), 64'd0);
            end
            check("bad_geom_single_err", 64'(err_cnt - e0), 64'd1);
            check("bad_geom_no_start", 64'(start_cnt - s0), 64'd0);
        end

        // Stall in ISSUE, then abort during the 5th command's WAIT
        hold = 1'b1;
        repeat (3) @(posedge clk);
        s0 = start_cnt; d0 = done_cnt; a0 = abort_cnt;
        start_job(32'h1000, 32'h2000, 8, 4);
        repeat (10) begin
            @(negedge clk);
            check("stall_no_start", 64'(o_start), 64'd0);
            check("stall_addr_stable", 64'(o_addr), 64'h1000);
        end
        hold = 1'b0;
        wait_for(0, s0 + 5, 200, "t5_fifth_start");
        @(posedge clk);
        #1;
        abort = 1'b1;
        wait_for(2, a0 + 1, 50, "t5_aborted_seen");
        abort = 1'b0;
        @(negedge clk);
        check("t5_busy_cleared", 64'(o_busy), 64'd0);
        repeat (5) @(negedge clk);
        check("t5_strobes", 64'(start_cnt - s0), 64'd5);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5_single_abort", 64'(abort_cnt - a0), 64'd1);
        exp_q.delete();

        // Abort while stalled in ISSUE
        hold = 1'b1;
        repeat (3) @(posedge clk);
        s0 = start_cnt; a0 = abort_cnt;
        start_job(32'h3000, 32'h4000, 4, 4);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        check("issue_abort_pulse", 64'(o_aborted), 64'd1);
        check("issue_abort_no_start", 64'(o_start), 64'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        check("issue_abort_idle", 64'(o_busy), 64'd0);
        check("issue_abort_strobes", 64'(start_cnt - s0), 64'd0);
        check("issue_abort_count", 64'(abort_cnt - a0), 64'd1);
        exp_q.delete();
        repeat (3) @(posedge clk);

        // Asynchronous reset during WAIT, then a fresh job
        s0 = start_cnt;
        start_job(32'h1000, 32'h2000, 4, 4);
        wait_for(0, s0 + 2, 100, "t6_second_start");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {o_start, o_addr, o_write, o_row_sel, o_busy, o_done, o_err, o_aborted}, 64'd0);
        check("async_reset_size", 64'(o_size), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        s0 = start_cnt; d0 = done_cnt;
        start_job(32'h1000, 32'h2000, 4, 4);
        wait_for(1, d0 + 1, 200, "t6_done_seen");
        check("t6_restart_first", 64'(log_q[0]), 64'h1000);
        check("t6_strobes", 64'(start_cnt - s0), 64'd8);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rot_tile_sched.md
# rot_tile_sched

Tile scheduler for the rotate engine. It walks a source image in 4x4-pixel tiles and drives the AHB DMA controller with single-word commands. For each tile it issues 4 row reads into the tile buffer, then 4 rotated row writes (90° clockwise) out of it. It sits between the register file, which supplies the image geometry and start pulse, and the DMA controller, which moves the data.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- DIM_W, 12, width of the image-dimension fields in pixels.

Ports:
- I_HCLK  in  1  clock; all logic is on the rising edge.
- I_HRESET_N  in  1  asynchronous, active-low reset.
- I_GO  in  1  start pulse; sampled only in IDLE.
- I_ABORT  in  1  level; stops the job at the next command boundary.
- I_SRC_ADDR  in  ADDR_W  source base address; word-aligned.
- I_DST_ADDR  in  ADDR_W  destination base address; word-aligned.
- I_WIDTH  in  DIM_W  source width W, in pixels (1 byte per pixel).
- I_HEIGHT  in  DIM_W  source height H, in pixels.
- I_DMA_READY  in  1  DMA controller idle / previous command complete.
- O_START  out  1  one-cycle DMA command strobe.
- O_ADDR  out  ADDR_W  command address.
- O_WRITE  out  1  0 = read (memory to buffer), 1 = write (buffer to memory).
- O_SIZE  out  1  constant 1 (word).
- O_COUNT  out  1  constant 0 (single beat).
- O_ROW_SEL  out  2  tile-buffer row (read) or column (write) index r/c for the current command.
- O_BUSY  out  1  job in progress.
- O_DONE  out  1  one-cycle pulse when the job completes normally.
- O_ERR  out  1  one-cycle pulse when the geometry is rejected.
- O_ABORTED  out  1  one-cycle pulse when the job ends because of I_ABORT.

## Operation
- States: IDLE, ISSUE, WAIT, ADV, FIN.
- Geometry check in IDLE when I_GO = 1:
  - Invalid if W = 0, H = 0, W[1:0] != 0, or H[1:0] != 0.
  - Invalid geometry: O_ERR pulse, stay in IDLE, no commands issued.
- Valid I_GO:
  - Latch all inputs, so later input changes are ignored.
  - Clear tx, ty, k and the phase; go to ISSUE.
- Tile order: raster over tiles. tx steps 0, 4, … W-4 (inner loop); ty steps 0, 4, … H-4 (outer loop).
- Per tile, 8 commands with k = 0..3 in each phase:
  - Read phase (O_WRITE = 0), row r = k: O_ADDR = SRC + (ty+r)·W + tx.
  - Write phase (O_WRITE = 1), column c = k: O_ADDR = DST + (tx+c)·H + (H-4-ty).
  - O_ROW_SEL = k in both phases.
- Arithmetic: products and sums are modulo 2^ADDR_W. Use either multipliers or incremental row pointers; the results must be identical.
- ISSUE: when I_DMA_READY = 1, assert O_START for that cycle and go to WAIT. Otherwise hold in ISSUE with O_START = 0.
- WAIT:
  - Ignore I_DMA_READY in the first WAIT cycle, because the DMA controller drops ready one cycle after O_START.
  - From the second WAIT cycle on, I_DMA_READY = 1 means the command is complete; go to ADV.
- ADV:
  - Increment k. On k wrap, toggle the phase.
  - On write-phase wrap, advance tx, or reset tx to 0 and advance ty.
  - If the final write of the final tile is done, go to FIN; else go to ISSUE.
- FIN: O_DONE = 1 for one cycle, then IDLE.
- I_ABORT:
  - In ISSUE: go to IDLE without strobing O_START; O_ABORTED pulses in that cycle.
  - In WAIT: finish the outstanding command, then go to IDLE instead of ADV; O_ABORTED pulses in the exit cycle.
  - O_DONE is never asserted for an aborted job.
- I_GO while busy is ignored.

## Timing
- Reset: state IDLE; every output 0 except O_SIZE = 1.
- I_GO at cycle n (ready already high): O_START at n+1.
- Minimum command period 4 cycles (ISSUE, WAIT, WAIT, ADV).
- O_ADDR, O_WRITE and O_ROW_SEL:
  - Registered, and valid from entry to ISSUE.
  - Held stable until the next ADV.
  - 0 in IDLE.
- O_BUSY:
  - 1 from the cycle after an accepted I_GO through FIN inclusive.
  - 1 through the abort exit cycle.
- O_DONE, O_ERR and O_ABORTED are mutually exclusive single-cycle pulses.
- A 4x4 image is the minimum job: exactly 8 commands.
- Asynchronous reset mid-job: return to IDLE immediately; no pulse outputs asserted.

## Test plan
- W=4, H=4, SRC=0x1000, DST=0x2000; DMA model ready 3 cycles after each start:
  - Reads 0x1000, 0x1004, 0x1008, 0x100C.
  - Writes 0x2000, 0x2004, 0x2008, 0x200C.
  - O_ROW_SEL 0-3 in each phase; then one O_DONE.
- W=8, H=4:
  - Tile 0 reads 0x1000, 0x1008, 0x1010, 0x1018; writes 0x2000-0x200C.
  - Tile 1 reads 0x1004-0x101C; writes 0x2010-0x201C.
  - 16 strobes total.
- W=4, H=8:
  - Tile ty=0 writes 0x2004, 0x200C, 0x2014, 0x201C.
  - Tile ty=4 reads 0x1010-0x101C; writes 0x2000, 0x2008, 0x2010, 0x2018.
- W=6 or H=0 -> single O_ERR pulse, O_START never asserted, O_BUSY stays 0.
- Hold I_DMA_READY = 0 for 10 cycles in ISSUE -> no O_START, address stable. Raise I_ABORT during the 5th command's WAIT -> command completes, O_ABORTED pulses, no O_DONE.
- Assert I_HRESET_N = 0 during WAIT -> all outputs reset immediately. A new I_GO after release -> restart from tile (0,0), read row 0.
